// File: rtl/split_pkg.sv
// Shared types and default geometry for the split line buffer and its controller.
package split_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_BURST_LENGTH  = 32;
  localparam int unsigned DEF_KERNEL_LENGTH = 3;
  localparam int unsigned DEF_MAX_ROWS      = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned ERR_CFG   = 0;
  localparam int unsigned ERR_EMPTY = 1;

endpackage

// File: rtl/split_beat_ctr.sv
// Beat/row counter pair for one frame: beats wrap per row burst, rows count up.
module split_beat_ctr #(
  parameter  int unsigned BURST_LENGTH  = 32,
  parameter  int unsigned KERNEL_LENGTH = 3,
  parameter  int unsigned ROW_W         = 11,
  localparam int unsigned BEAT_W        = $clog2(BURST_LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [ROW_W-1:0] rows_q,
  output logic             prime_end_c,
  output logic             last_row_c
);

  logic [BEAT_W-1:0] beat_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [ROW_W-1:0]  row_nxt;
  logic              row_end;

  assign row_nxt     = row_cnt + ROW_W'(1);
  assign row_end     = inc && (beat_cnt == BEAT_W'(BURST_LENGTH - 1));
  assign prime_end_c = row_end && (row_nxt == ROW_W'(KERNEL_LENGTH - 1));
  assign last_row_c  = row_end && (row_nxt == rows_q);

  // BURST_LENGTH is a power of two, so the beat counter wraps on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      row_cnt  <= '0;
    end else if (clr) begin
      beat_cnt <= '0;
      row_cnt  <= '0;
    end else if (inc) begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
      if (row_end) row_cnt <= row_nxt;
    end
  end

endmodule

// File: rtl/split_ctrl.sv
// Sequencer feeding DMA row bursts into the split line buffer: prime K-1 rows, then stream.
module split_ctrl
  import split_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int unsigned BURST_LENGTH  = DEF_BURST_LENGTH,
  parameter  int unsigned KERNEL_LENGTH = DEF_KERNEL_LENGTH,
  parameter  int unsigned MAX_ROWS      = DEF_MAX_ROWS,
  localparam int unsigned ROW_W         = $clog2(MAX_ROWS + 1),
  localparam int unsigned COL_W         = $clog2(BURST_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ROW_W-1:0]      cfg_rows,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  wen,
  output logic                  ren,
  output logic [DATA_WIDTH-1:0] din,
  input  logic                  full_flag,
  input  logic                  empty_flag,
  input  logic                  valid,
  output logic                  win_valid,
  output logic [COL_W-1:0]      col_idx,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err
);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [1:0]       err_d;
  logic             clr;
  logic             accept;
  logic             prime_end;
  logic             last_row;

  assign s_ready = ((state_q == ST_PRIME) || (state_q == ST_STREAM)) &&
                   !full_flag && !err[ERR_EMPTY];
  assign accept  = s_valid && s_ready;

  split_beat_ctr #(
    .BURST_LENGTH (BURST_LENGTH),
    .KERNEL_LENGTH(KERNEL_LENGTH),
    .ROW_W        (ROW_W)
  ) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .inc        (accept),
    .rows_q     (rows_q),
    .prime_end_c(prime_end),
    .last_row_c (last_row)
  );

  // Next-state, frame config and sticky error logic.
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    err_d   = err;
    clr     = 1'b0;
    if ((state_q == ST_STREAM) && ren && empty_flag) err_d[ERR_EMPTY] = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_rows >= ROW_W'(KERNEL_LENGTH)) begin
            state_d = ST_PRIME;
            rows_d  = cfg_rows;
            err_d   = 2'b00;
            clr     = 1'b1;
          end else begin
            err_d[ERR_CFG] = 1'b1;
          end
        end
      end
      ST_PRIME:  if (prime_end) state_d = ST_STREAM;
      ST_STREAM: if (last_row) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rows_q    <= '0;
      err       <= 2'b00;
      wen       <= 1'b0;
      ren       <= 1'b0;
      din       <= '0;
      win_valid <= 1'b0;
      col_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      err       <= err_d;
      wen       <= accept;
      ren       <= accept && (state_q == ST_STREAM);
      if (accept) din <= s_data;
      win_valid <= valid;
      // Realign at stream entry; each later row yields exactly BURST_LENGTH columns and wraps.
      if (clr || prime_end)  col_idx <= '0;
      else if (win_valid)    col_idx <= col_idx + COL_W'(1);
      busy      <= (state_d == ST_PRIME) || (state_d == ST_STREAM);
      done      <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_split_ctrl.sv
// Randomised bench for split_ctrl; split's flags and column valid are driven by the bench.
module tb_split_ctrl;

  localparam int unsigned B  = 32;
  localparam int unsigned K  = 3;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [10:0]   cfg_rows;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          wen, ren;
  logic [DW-1:0] din;
  logic          full_flag, empty_flag, valid;
  logic          win_valid;
  logic [4:0]    col_idx;
  logic          busy, done;
  logic [1:0]    err;

  split_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wen(wen), .ren(ren), .din(din),
    .full_flag(full_flag), .empty_flag(empty_flag), .valid(valid),
    .win_valid(win_valid), .col_idx(col_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame progress as accepted-beat count against row arithmetic.
  logic          m_active;
  int            m_beats, m_total, m_cols;
  logic [1:0]    m_err;
  logic          e_wen, e_ren, e_done, e_busy, e_win, prev_ren;
  logic [DW-1:0] e_din;
  int            wen_cnt, ren_cnt, win_cnt, full_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_active = 1'b0; m_beats = 0; m_total = 0; m_cols = 0; m_err = 2'b00;
    e_wen = 1'b0; e_ren = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_win = 1'b0;
    prev_ren = 1'b0; e_din = '0;
  endtask

  task automatic cycle(input logic v, input logic full, input logic empty,
                       input logic st, input int rows);
    logic          xfer, n_wen, n_ren, n_done;
    logic          exp_ready;
    logic [DW-1:0] d;
    @(negedge clk);
    chk("wen", wen, e_wen);
    chk("ren", ren, e_ren);
    chk("din", din, e_din);
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("win_valid", win_valid, e_win);
    chk("col_idx", col_idx, m_cols % B);
    chk("err", err, m_err);
    if (wen) wen_cnt++;
    if (ren) ren_cnt++;
    if (win_valid) win_cnt++;
    d = $urandom;
    s_valid = v; s_data = d; full_flag = full; empty_flag = empty;
    start = st; cfg_rows = 11'(rows);
    valid = prev_ren;
    #1;
    exp_ready = m_active && !full && !m_err[1];
    chk("s_ready", s_ready, exp_ready);
    xfer = v && exp_ready;
    if (e_win) m_cols = (m_cols + 1) % B;
    if (e_ren && empty && m_active) m_err[1] = 1'b1;
    if (st && !m_active && !e_done) begin
      if (rows < K) m_err[0] = 1'b1;
      else begin
        m_err = 2'b00; m_active = 1'b1; m_beats = 0; m_total = rows * B; m_cols = 0;
      end
    end
    n_wen = xfer;
    n_ren = xfer && (m_beats >= (K - 1) * B);
    n_done = 1'b0;
    if (xfer) begin
      e_din = d;
      m_beats++;
      if (m_beats == m_total) begin
        n_done = 1'b1;
        m_active = 1'b0;
      end
    end
    prev_ren = e_ren;
    e_wen = n_wen; e_ren = n_ren; e_done = n_done;
    e_busy = m_active;
    e_win = valid;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; full_flag = 1'b0;
    empty_flag = 1'b0; valid = 1'b0;
    repeat (n) begin
      #1;
      chk("rst_wen", wen, 0);
      chk("rst_ren", ren, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_done", done, 0);
      chk("rst_din", din, 0);
      chk("rst_col_idx", col_idx, 0);
      @(negedge clk);
    end
    rst = 1'b1;
    model_clear();
  endtask

  task automatic step(input int mode, input int c);
    logic v, full;
    full = 1'b0;
    case (mode)
      0: v = 1'b1;
      1: v = (c % 2 == 0);
      2: begin
        v = ($urandom_range(3, 0) != 0);
        full = ($urandom_range(9, 0) == 0);
      end
      default: begin
        v = 1'b1;
        full = (m_beats == 20) && (full_cnt < 5);
        if (full) full_cnt++;
      end
    endcase
    cycle(v, full, 1'b0, 1'b0, 0);
    if (full && mode == 3) chk("beat_cnt_hold", dut.u_ctr.beat_cnt, 20);
  endtask

  task automatic run_beats(input int stop, input int mode);
    for (int c = 0; c < 5000 && m_active && m_beats < stop; c++) step(mode, c);
  endtask

  task automatic run_frame(input int rows, input int mode);
    wen_cnt = 0; ren_cnt = 0; win_cnt = 0; full_cnt = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, rows);
    run_beats(1 << 30, mode);
    for (int c = 0; c < 4 && (e_wen || e_done); c++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("frame_busy_low", busy, 0);
    chk("wen_total", wen_cnt, rows * B);
    chk("ren_total", ren_cnt, (rows - K + 1) * B);
    chk("win_total", win_cnt, (rows - K + 1) * B);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg_rows = '0; s_valid = 1'b0; s_data = '0;
    full_flag = 1'b0; empty_flag = 1'b0; valid = 1'b0;
    model_clear();
    do_reset(2);

    run_frame(3, 0);
    run_frame(5, 1);

    // Too few rows: flagged, no frame.
    wen_cnt = 0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 2);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("short_no_wen", wen_cnt, 0);
    chk("short_err", err, 2'b01);
    run_frame(3, 0);

    // Back-pressure for 5 cycles at priming beat 20.
    run_frame(3, 3);

    for (int i = 0; i < 4; i++) run_frame(int'($urandom_range(6, 3)), int'($urandom_range(2, 0)));

    // Reset mid-stream, then a clean frame.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 3);
    run_beats(2 * B + 10, 0);
    do_reset(2);
    run_frame(3, 0);

    // Read while split is empty: sticky error, intake stops, start ignored.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4);
    run_beats(2 * B + 2, 0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 3);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("empty_err_bit", err[1], 1);
    chk("empty_busy_hold", busy, 1);
    do_reset(2);
    run_frame(3, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
